// File: rtl/uart_pkg.sv
// Shared UART definitions: one baud constant for both ends of the link and
// the receiver state encoding.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 32'd1250;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte and strobes out.
// The master modport is the receiver itself; slave is the pin driver / consumer.
interface uart_rx_if;
  logic       i_rx_serial;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    input  i_rx_serial,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    output i_rx_serial,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin, with a selectable
// reset value so an idle-high line does not look active out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: meta captures the raw pin, q is safe to use.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling of 8 data bits
// LSB first, stop-bit check, and break suppression after a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 32'd1) / 32'd2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'd1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          err_r;
  logic          busy_r;
  logic          rx_s;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.i_rx_serial),
    .q   (rx_s)
  );

  // Frame FSM; busy is tracked alongside each transition so it stays a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      shift   <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= ST_START;
            busy_r <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= 3'd0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            shift[idx] <= rx_s;
            cnt        <= '0;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_r  <= shift;
              valid_r <= 1'b1;
              state   <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              err_r <= 1'b1;
              state <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_BREAK: begin
          // A held-low line must not be decoded as a stream of 0x00 frames.
          cnt <= '0;
          if (rx_s) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data      = data_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_frame_err = err_r;
  assign bus.o_busy      = busy_r;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for 8N1 UART frames, the receive-side counterpart of the design's UART transmitter. It sits between the board RX pin and the byte-oriented logic that consumes received data. It synchronises the asynchronous line and validates the start bit at mid-bit. It then samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each byte with a one-cycle valid strobe or a framing-error strobe.

## Interface
- CLKS_PER_BIT, 1250, clk cycles per bit period; legal range ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_rx_serial  input  1  asynchronous serial line, idle high.
- o_data  output  8  last correctly framed byte; held until the next valid frame.
- o_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  output  1  high in every state except IDLE.

## Operation
- Input path: 2-flop synchroniser on i_rx_serial produces rx_s. rx_s is reset to 1. No logic uses the raw pin.
- HALF = (CLKS_PER_BIT-1)/2, using integer division. Bit counter width = $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: counter = 0. rx_s == 0 moves to START.
  - START: counter increments each cycle. At counter == HALF, sample rx_s:
    - rx_s 0: counter cleared, bit index cleared, go to DATA.
    - rx_s 1 (glitch): go to IDLE with no output pulse.
  - DATA: at counter == CLKS_PER_BIT-1, shift rx_s into shift[index], clear counter, and increment index. After index 7 is sampled, go to STOP.
  - STOP: at counter == CLKS_PER_BIT-1, sample rx_s:
    - rx_s 1: o_data ← shift, o_valid pulse, go to IDLE.
    - rx_s 0: o_frame_err pulse, o_data unchanged, go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from being read as repeated 0x00 frames.
- Data order is LSB first. Parity is not supported.
- o_valid and o_frame_err are mutually exclusive and never high for two consecutive cycles.

## Timing
- Reset values: o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0, state = IDLE, synchroniser flops = 1.
- A reset asserted mid-frame aborts the frame with no pulse. After reset releases, a line that is still low is treated as a new start edge.
- Synchroniser latency is 2 cycles from pin to rx_s.
- Let cycle T be the first cycle with rx_s == 0 in IDLE.
  - Start sample: T+1+HALF.
  - Data bit k sample: T+1+HALF + (k+1)·CLKS_PER_BIT.
  - Stop sample: T+1+HALF + 9·CLKS_PER_BIT.
  - o_valid / o_frame_err are high in the cycle after the stop sample.
- Back-to-back frames are accepted. The FSM is back in IDLE about half a bit before the end of the stop bit, so the next start edge is caught.
- Downstream must consume o_data in the o_valid cycle or before the next o_valid. There is no backpressure and no overrun flag.
- Tolerance: a per-frame baud mismatch of ±4% must still decode correctly.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (typedef, 3 bits) for IDLE/START/DATA/STOP/BREAK;
  - the default CLKS_PER_BIT constant, shared with the transmitter so both ends use one baud definition.
- One sub-module is natural: uart_rx_sync, a 2-flop synchroniser with reset value 1. It is reusable for other asynchronous pins.
- The FSM, counter, index and shift register stay in uart_rx.

## Test plan
Simulate with CLKS_PER_BIT = 16.
- Reset then idle line: all outputs keep their reset values for 1000 cycles, o_busy = 0.
- Send 0xA5 in 8N1 → exactly one o_valid, o_data = 8'hA5 in the cycle after stop sample (T+1+7+144), o_frame_err never high.
- Send 0x00 and 0xFF back-to-back with no idle gap → two o_valid pulses, o_data = 8'h00 then 8'hFF.
- Low glitch of 5 cycles on idle line → returns to IDLE, no o_valid or o_frame_err. o_busy is high only during the glitch check.
- Frame 0x3C with stop bit low, line held low for 40 more bit times → one o_frame_err, o_data keeps its previous value. No further pulses until the line returns high. The next good frame 0x81 is then received.
- Assert rst during bit 4 of a frame → no pulse, outputs at reset values. The next full frame 0x5A is received correctly.
- Bit periods of 15 and 17 cycles (±6% on a 16-cycle bit, beyond the ±4% requirement) with byte 0xC3 → received as 0xC3.
